// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter FSM state encoding.
package uart_pkg;
    localparam int   FRAME_LEN = 10;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   MIN_BAUD  = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} tx_state_e;
endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one 8N1 frame; done pulses in the last cycle of the stop bit.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int W_BAU = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_BAU-1:0] baud,
    input  logic [7:0]       byt,
    input  logic             go,
    output logic             done,
    output logic             txd
);
    // txd_q is the low end of the frame register; sh_q holds the bits still to go.
    logic [FRAME_LEN-2:0] sh_q;
    logic [W_BAU-1:0]     cnt_q;
    logic [3:0]           bit_q;
    logic                 bsy_q;
    logic                 txd_q;
    logic                 tick;

    assign tick = bsy_q && (cnt_q == W_BAU'(1));
    assign done = tick && (bit_q == 4'(FRAME_LEN - 1));
    assign txd  = txd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            bit_q <= '0;
            bsy_q <= 1'b0;
            txd_q <= STOP_BIT;
        end else if (go) begin
            // go may coincide with the final tick of the previous frame
            sh_q  <= {STOP_BIT, byt};
            cnt_q <= baud;
            bit_q <= '0;
            bsy_q <= 1'b1;
            txd_q <= START_BIT;
        end else if (tick) begin
            cnt_q <= baud;
            if (done) begin
                bsy_q <= 1'b0;
                txd_q <= STOP_BIT;
            end else begin
                txd_q <= sh_q[0];
                sh_q  <= {STOP_BIT, sh_q[FRAME_LEN-2:1]};
                bit_q <= bit_q + 4'd1;
            end
        end else if (bsy_q) begin
            cnt_q <= cnt_q - W_BAU'(1);
        end
    end
endmodule

// File: rtl/uart_tx.sv
// Multi-byte UART transmitter: latches an N_BYT-byte word and sends it MSB byte first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int N_BYT = 4,
    parameter int W_BAU = 10,
    parameter int N_GAP = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_BAU-1:0]   baud,
    input  logic [8*N_BYT-1:0] dat,
    input  logic               start,
    output logic               f_bsy,
    output logic               f_fin,
    output logic               uart_txd
);
    localparam int W_CNT = $clog2(N_BYT + 1);
    localparam int W_GAP = W_BAU + 2;

    tx_state_e          state_q;
    logic [8*N_BYT-1:0] dat_buf_q;
    logic [W_BAU-1:0]   bau_buf_q;
    logic [W_CNT-1:0]   cnt_q;
    logic [W_GAP-1:0]   gap_q;
    logic               f_bsy_q;
    logic               f_fin_q;

    logic               accept, more, byte_done, gap_end, go;
    logic [W_BAU-1:0]   bau_d, bau_sel;
    logic [7:0]         byt_sel;
    logic [W_GAP-1:0]   gap_len;

    assign bau_d   = (baud < W_BAU'(MIN_BAUD)) ? W_BAU'(MIN_BAUD) : baud;
    assign accept  = (state_q == ST_IDLE) && start;
    assign more    = (cnt_q != '0);
    assign gap_end = (state_q == ST_GAP) && (gap_q == W_GAP'(1));
    assign gap_len = W_GAP'(N_GAP) * W_GAP'(bau_buf_q);

    // The next byte is launched on the edge the previous stop bit ends, so LOAD costs no line time.
    assign go = accept || gap_end ||
                ((state_q == ST_SEND) && byte_done && more && (N_GAP == 0));
    assign byt_sel = accept ? dat[8*N_BYT-1 -: 8] : dat_buf_q[8*N_BYT-1 -: 8];
    assign bau_sel = accept ? bau_d : bau_buf_q;

    assign f_bsy = f_bsy_q;
    assign f_fin = f_fin_q;

    uart_tx_byte #(.W_BAU(W_BAU)) u_byte (
        .clk  (clk),
        .rst  (rst),
        .baud (bau_sel),
        .byt  (byt_sel),
        .go   (go),
        .done (byte_done),
        .txd  (uart_txd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dat_buf_q <= '0;
            bau_buf_q <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            f_bsy_q   <= 1'b0;
            f_fin_q   <= 1'b0;
        end else begin
            f_fin_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    f_bsy_q <= start;
                    if (start) begin
                        dat_buf_q <= dat;
                        bau_buf_q <= bau_d;
                        cnt_q     <= W_CNT'(N_BYT);
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dat_buf_q <= dat_buf_q << 8;
                    cnt_q     <= cnt_q - W_CNT'(1);
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    if (byte_done) begin
                        if (!more) begin
                            state_q <= ST_IDLE;
                            f_fin_q <= 1'b1;
                        end else if (N_GAP == 0) begin
                            state_q <= ST_LOAD;
                        end else begin
                            gap_q   <= gap_len;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_end) state_q <= ST_LOAD;
                    else         gap_q   <= gap_q - W_GAP'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line model decodes TxD against a queue of expected bytes.
module tb_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  baud0 = '0, baud1 = '0;
    logic [31:0] dat0 = '0;
    logic [15:0] dat1 = '0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        f_bsy0, f_fin0, txd0, f_bsy1, f_fin1, txd1;
    bit          mon0 = 1'b1, mon1 = 1'b1;
    int          n_chk = 0, n_fail = 0;
    logic        tr [1:90];

    typedef struct {
        logic [7:0] byt;
        int         bd;
    } frm_t;
    frm_t sb0[$], sb1[$];

    always #5 clk = ~clk;

    uart_tx #(.N_BYT(4), .W_BAU(10), .N_GAP(0)) u_dut (
        .clk(clk), .rst(rst), .baud(baud0), .dat(dat0), .start(start0),
        .f_bsy(f_bsy0), .f_fin(f_fin0), .uart_txd(txd0)
    );

    uart_tx #(.N_BYT(2), .W_BAU(10), .N_GAP(2)) u_gap (
        .clk(clk), .rst(rst), .baud(baud1), .dat(dat1), .start(start1),
        .f_bsy(f_bsy1), .f_fin(f_fin1), .uart_txd(txd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [31:0] d, input int nb, input int bd);
        frm_t f;
        for (int i = nb - 1; i >= 0; i--) begin
            f.byt = d[8*i +: 8];
            f.bd  = bd;
            if (sel) sb1.push_back(f);
            else     sb0.push_back(f);
        end
    endtask

    // Line model: every cycle of a frame must match start/data/stop at exactly bd cycles per bit.
    task automatic watch(input bit sel);
        frm_t       e;
        logic       ln, el;
        logic [7:0] got;
        bit         en, ok;
        int         n, b;
        string      tg;
        tg = sel ? "txd1" : "txd0";
        forever begin
            @(negedge clk);
            ln = sel ? txd1 : txd0;
            en = sel ? mon1 : mon0;
            if (en && !rst && ln === 1'b0) begin
                n = sel ? sb1.size() : sb0.size();
                chk({tg, "_expected_frame"}, 32'(n != 0), 32'd1);
                if (n != 0) begin
                    if (sel) e = sb1.pop_front();
                    else     e = sb0.pop_front();
                    got = '0;
                    ok  = 1'b1;
                    for (int k = 0; k < 10 * e.bd && ok; k++) begin
                        if (k != 0) begin
                            @(negedge clk);
                            ln = sel ? txd1 : txd0;
                            en = sel ? mon1 : mon0;
                        end
                        if (rst || !en) ok = 1'b0;
                        else begin
                            b = k / e.bd;
                            if (b == 0)      el = 1'b0;
                            else if (b == 9) el = 1'b1;
                            else             el = e.byt[b-1];
                            chk({tg, "_line"}, 32'(ln), 32'(el));
                            if (b >= 1 && b <= 8 && (k % e.bd) == e.bd / 2) got[b-1] = ln;
                        end
                    end
                    if (ok) chk({tg, "_byte"}, 32'(got), 32'(e.byt));
                end
            end
        end
    endtask

    initial watch(1'b0);
    initial watch(1'b1);

    initial begin
        @(negedge clk);
        chk("rst_txd0", 32'(txd0), 32'd1);
        chk("rst_bsy0", 32'(f_bsy0), 32'd0);
        chk("rst_fin0", 32'(f_fin0), 32'd0);
        chk("rst_txd1", 32'(txd1), 32'd1);
        chk("rst_bsy1", 32'(f_bsy1), 32'd0);
        chk("rst_fin1", 32'(f_fin1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // basic frame, with an ignored start pulse while busy
        baud0 = 10'd4; dat0 = 32'h12345678; push(1'b0, dat0, 4, 4); start0 = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            if (k == 1 || k == 51) start0 = 1'b0;
            if (k == 50) start0 = 1'b1;
            if (k == 1) chk("basic_first_start", 32'(txd0), 32'd0);
            chk("basic_fin", 32'(f_fin0), 32'(k == 161));
            chk("basic_bsy", 32'(f_bsy0), 32'(k <= 161));
        end

        // clamped baud 0 must match baud 2 cycle for cycle
        baud0 = 10'd0; dat0 = 32'hFF00AA55; push(1'b0, dat0, 4, 2); start0 = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (k == 1) start0 = 1'b0;
            tr[k] = txd0;
            chk("clamp0_fin", 32'(f_fin0), 32'(k == 81));
        end
        baud0 = 10'd2; push(1'b0, dat0, 4, 2); start0 = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (k == 1) start0 = 1'b0;
            chk("clamp_wave", 32'(txd0), 32'(tr[k]));
            chk("clamp2_fin", 32'(f_fin0), 32'(k == 81));
        end

        // start held: back-to-back; baud/dat changed mid-flight apply only to the next word
        baud0 = 10'd4; dat0 = 32'hDEADBEEF; push(1'b0, dat0, 4, 4); start0 = 1'b1;
        for (int k = 1; k <= 530; k++) begin
            @(negedge clk);
            if (k == 1) begin
                baud0 = 10'd9; dat0 = 32'h0F1E2D3C; push(1'b0, dat0, 4, 9);
            end
            if (k == 162) start0 = 1'b0;
            chk("b2b_fin", 32'(f_fin0), 32'((k == 161) || (k == 522)));
            chk("b2b_bsy", 32'(f_bsy0), 32'(k <= 522));
            if (k == 161) chk("b2b_mark", 32'(txd0), 32'd1);
            if (k == 162) chk("b2b_start", 32'(txd0), 32'd0);
        end

        // inter-byte gap of 2 bit periods
        baud1 = 10'd3; dat1 = 16'hA53C; push(1'b1, {16'h0, dat1}, 2, 3); start1 = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (k == 1) start1 = 1'b0;
            chk("gap_fin", 32'(f_fin1), 32'(k == 67));
            chk("gap_bsy", 32'(f_bsy1), 32'(k <= 67));
            if (k >= 31 && k <= 36) chk("gap_mark", 32'(txd1), 32'd1);
            if (k == 37) chk("gap_start2", 32'(txd1), 32'd0);
        end

        // asynchronous reset in byte 2, frame bit 4 (line low there for 0xA5)
        baud0 = 10'd4; dat0 = 32'hC3A50F96; push(1'b0, dat0, 4, 4); start0 = 1'b1;
        for (int k = 1; k <= 58; k++) begin
            @(negedge clk);
            if (k == 1) start0 = 1'b0;
            if (k == 55) mon0 = 1'b0;
        end
        chk("pre_rst_txd", 32'(txd0), 32'd0);
        chk("pre_rst_bsy", 32'(f_bsy0), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_txd", 32'(txd0), 32'd1);
        chk("rst_async_bsy", 32'(f_bsy0), 32'd0);
        chk("rst_async_fin", 32'(f_fin0), 32'd0);
        sb0.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("post_rst_txd", 32'(txd0), 32'd1);
            chk("post_rst_bsy", 32'(f_bsy0), 32'd0);
        end
        mon0 = 1'b1;

        repeat (5) @(negedge clk);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Multi-byte UART transmitter, the transmit counterpart of the team's multi-byte UART receiver. On a start strobe it latches an N_BYT-byte word and a baud divider, then serialises the bytes on TxD, most-significant byte first. Each byte is sent as an 8N1 frame. It sits between the RTMQ host-link logic and the board TxD pin, and signals a one-cycle finish pulse when the last stop bit completes.

Parameters:
N_BYT, 4, number of bytes sent per transaction (1..16).
W_BAU, 10, width of the baud divider (clock cycles per bit).
N_GAP, 0, extra idle (mark) bit periods inserted between consecutive bytes (0..3).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
baud  input  W_BAU  clock cycles per bit; sampled only at accept; values <2 treated as 2.
dat  input  8*N_BYT  word to send; sampled only at accept.
start  input  1  transaction request; level, sampled each cycle.
f_bsy  output  1  high from the cycle after accept until f_fin, inclusive of the last stop bit.
f_fin  output  1  one-cycle pulse at the end of the transaction.
uart_txd  output  1  TxD line, driven from a registered (IOB) flop.

Behaviour:
- Reset (asynchronous, active-high): uart_txd=1, f_bsy=0, f_fin=0, all counters and shift buffers cleared, state IDLE. Asserting reset mid-frame forces uart_txd high immediately, with no glitch low; the partial frame is abandoned.
- Accept: start=1 in IDLE at edge t0. Latch dat into the word buffer, latch max(baud,2) into bau_buf, and set the byte counter to N_BYT.
- f_bsy is high from t0+1.
- Top-level FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle) hands the top byte dat_buf[8*N_BYT-1 -: 8] to the sub-module and shifts the word buffer left by 8.
  - SEND waits for the sub-module's done signal.
  - On done: if bytes remain, go to GAP (N_GAP*baud cycles; skipped when N_GAP=0) then LOAD. Otherwise go to IDLE and pulse f_fin.
- Frame timing per byte:
  - Start bit 0, then data bits 0..7 (LSB first), then stop bit 1. Each bit lasts exactly bau_buf cycles.
  - The line changes only on baud-tick boundaries.
  - The LOAD cycle is absorbed: the first start bit goes low at t0+1. Subsequent bytes start immediately at the previous stop-bit end, or after the gap.
- Total duration: uart_txd is low at t0+1. The transaction occupies T = N_BYT*10*baud + (N_BYT-1)*N_GAP*baud cycles. f_fin=1 in cycle t0+1+T, the same cycle f_bsy falls.
- start while f_bsy=1 is ignored. start held high continuously re-accepts at the f_fin cycle, giving back-to-back transactions with no idle cycle.
- baud and dat may change freely after accept without affecting the transaction in flight.
- The baud counter loads bau_buf and decrements; a tick fires when the count reaches 1. Wrap is impossible because bau_buf>=2.

Decomposition:
- Constants live in a shared package (uart_pkg): frame length 10, start/stop bit values, minimum baud 2. The receiver also uses this package.
- One sub-module, uart_tx_byte. It takes clk, rst, baud, byt, go, done and txd, and contains the baud counter, the 10-bit shift register (loaded with {1,byt,0}) and the bit counter.
  - done is a one-cycle pulse at the end of the stop bit.
  - txd idles high.
- The top level owns the word buffer, byte counter, gap counter, FSM and f_fin.

Test Plan:
- Reset check: reset asserted mid-frame (byte 2, bit 4) -> uart_txd=1 and f_bsy=0 within the same cycle (asynchronous). After release, no output until the next start.
- Basic frame: baud=4, N_BYT=4, dat=0x12345678, single-cycle start at t0.
  - Line pattern per byte, bits of 4 cycles each: 0x12 -> 0,0,1,0,0,1,0,0,0,1.
  - Byte order 12,34,56,78.
  - f_fin=1 only at t0+161.
  - f_bsy high over t0+1..t0+161.
- Minimum and clamped baud: baud=0 and baud=2 give identical waveforms (2 cycles/bit). dat=0xFF00AA55 decodes correctly in a bench UART model.
- Busy and back-to-back: start pulsed at t0+50 is ignored. start held high gives the second transaction's start bit at t0+162 with no idle cycles.
- Mid-flight changes: baud changed from 4 to 9 and dat changed mid-transaction -> the current transaction keeps 4 cycles/bit and the original data; the next transaction uses 9.
- Gap: N_GAP=2, baud=3, N_BYT=2 -> 6 mark cycles between the stop bit of byte 1 and the start bit of byte 2; f_fin at t0+1+66.
